// File: rtl/darkcore_mt.sv
// darkcore_mt: multi-thread RV32I execute/writeback datapath.
// Per-thread register banks, registered nxpc, byte lanes and same-thread forwarding.
module darkcore_mt #(
  parameter int          THREADS  = 2,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] RESET_SP = 32'd4096,
  localparam int         TID_W    = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en_al,
  input  logic [TID_W-1:0] tid_al,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  output logic             valid_al,
  output logic [31:0]      addr_al,
  output logic [31:0]      data_al,
  output logic [3:0]       be_al,
  output logic             misal_al,
  output logic [31:0]      nxpc,
  input  logic             en_wb,
  input  logic [31:0]      data_wb,
  output logic             valid_wb
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_ALU  = 2'd1;
  localparam logic [1:0] K_LOAD = 2'd2;

  logic [31:0] rf [THREADS][32];

  logic [0:0]       state;
  logic [TID_W-1:0] p_tid;
  logic [4:0]       p_rd;
  logic [1:0]       p_kind;
  logic [2:0]       p_fct3;
  logic [1:0]       p_a;
  logic [31:0]      p_res;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_opi, is_op;
  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6f;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_opi   = opc == 7'h13;
  assign is_op    = opc == 7'h33;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  logic [31:0] lane, ld_val, wb_val;
  logic        wb_do;
  always_comb begin
    lane = data_wb >> {p_a, 3'b000};
    unique case (p_fct3[1:0])
      2'b00:   ld_val = {{24{lane[7] & ~p_fct3[2]}}, lane[7:0]};
      2'b01:   ld_val = {{16{lane[15] & ~p_fct3[2]}}, lane[15:0]};
      default: ld_val = data_wb;
    endcase
    wb_val = (p_kind == K_LOAD) ? ld_val : p_res;
    wb_do  = en_wb && state == PEND &&
             p_kind != K_NONE && p_rd != 5'd0;
  end

  // the pending result is committed before the new operands are read
  logic        fwd;
  logic [31:0] a, b;
  always_comb begin
    fwd = wb_do && p_tid == tid_al;
    a = (fwd && p_rd == rs1) ? wb_val : rf[tid_al][rs1];
    b = (fwd && p_rd == rs2) ? wb_val : rf[tid_al][rs2];
  end

  logic [31:0] alu_b, alu;
  logic [4:0]  shamt;
  always_comb begin
    alu_b = is_op ? b : imm_i;
    shamt = alu_b[4:0];
    unique case (f3)
      3'd0: alu = (is_op && inst[30]) ? a - alu_b : a + alu_b;
      3'd1: alu = a << shamt;
      3'd2: alu = {31'b0, $signed(a) < $signed(alu_b)};
      3'd3: alu = {31'b0, a < alu_b};
      3'd4: alu = a ^ alu_b;
      3'd5: alu = inst[30] ? 32'($signed(a) >>> shamt)
                           : a >> shamt;
      3'd6: alu = a | alu_b;
      default: alu = a & alu_b;
    endcase
  end

  logic taken;
  always_comb begin
    unique case (f3)
      3'd0: taken = a == b;
      3'd1: taken = a != b;
      3'd4: taken = $signed(a) < $signed(b);
      3'd5: taken = $signed(a) >= $signed(b);
      3'd6: taken = a < b;
      3'd7: taken = a >= b;
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] ea, sdata;
  logic [3:0]  be_v;
  logic        mis;
  always_comb begin
    ea    = a + (is_st ? imm_s : imm_i);
    be_v  = 4'b0;
    mis   = 1'b0;
    sdata = 32'b0;
    if (is_ld || is_st) begin
      unique case (f3[1:0])
        2'b00: be_v = 4'b0001 << ea[1:0];
        2'b01: begin
          mis  = ea[0];
          be_v = mis ? 4'b0 : (ea[1] ? 4'b1100 : 4'b0011);
        end
        default: begin
          mis  = ea[1:0] != 2'b00;
          be_v = mis ? 4'b0 : 4'b1111;
        end
      endcase
    end
    if (is_st) begin
      unique case (f3[1:0])
        2'b00:   sdata = {4{b[7:0]}};
        2'b01:   sdata = {2{b[15:0]}};
        default: sdata = b;
      endcase
    end
  end

  logic [31:0] res_v, nx;
  logic [1:0]  kind;
  always_comb begin
    res_v = alu;
    kind  = K_NONE;
    nx    = pc + 32'd4;
    unique case (1'b1)
      is_lui:   begin res_v = imm_u;        kind = K_ALU; end
      is_auipc: begin res_v = pc + imm_u;   kind = K_ALU; end
      is_jal: begin
        res_v = pc + 32'd4;
        kind  = K_ALU;
        nx    = pc + imm_j;
      end
      is_jalr: begin
        res_v = pc + 32'd4;
        kind  = K_ALU;
        nx    = (a + imm_i) & ~32'd1;
      end
      is_br:    if (taken) nx = pc + imm_b;
      is_opi:   kind = K_ALU;
      is_op:    kind = K_ALU;
      is_ld:    kind = mis ? K_NONE : K_LOAD;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      valid_al <= 1'b0;
      valid_wb <= 1'b0;
      addr_al  <= 32'b0;
      data_al  <= 32'b0;
      be_al    <= 4'b0;
      misal_al <= 1'b0;
      nxpc     <= RESET_PC;
      p_tid    <= '0;
      p_rd     <= 5'b0;
      p_kind   <= K_NONE;
      p_fct3   <= 3'b0;
      p_a      <= 2'b0;
      p_res    <= 32'b0;
      for (int t = 0; t < THREADS; t++)
        for (int r = 0; r < 32; r++)
          rf[t][r] <= (r == 2) ? RESET_SP : 32'b0;
    end else begin
      valid_al <= en_al;
      valid_wb <= en_wb && state == PEND;
      if (wb_do)
        rf[p_tid][p_rd] <= wb_val;
      if (en_al) begin
        state    <= PEND;
        addr_al  <= ea;
        data_al  <= sdata;
        be_al    <= be_v;
        misal_al <= mis;
        nxpc     <= nx;
        p_tid    <= tid_al;
        p_rd     <= rd;
        p_kind   <= kind;
        p_fct3   <= f3;
        p_a      <= ea[1:0];
        p_res    <= res_v;
      end else if (en_wb && state == PEND) begin
        state <= IDLE;
      end
    end
  end

endmodule
